// File: rtl/wb_pkg.sv
// Shared Wishbone types and constants for the two-master RAM arbiter.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;
  localparam int unsigned WB_CTI_W  = 3;

  localparam logic [WB_CTI_W-1:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [WB_CTI_W-1:0] WB_CTI_INCR    = 3'b010;
  localparam logic [WB_CTI_W-1:0] WB_CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } arb_state_e;

endpackage

// File: rtl/wb_arb2_if.sv
// One Wishbone pipelined link; master modport drives the request, slave modport the response.
interface wb_arb2_if;
  import wb_pkg::*;

  logic [WB_ADDR_W-1:0] addr;
  logic [WB_DATA_W-1:0] dat_w;
  logic [WB_SEL_W-1:0]  sel;
  logic [WB_CTI_W-1:0]  cti;
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [WB_DATA_W-1:0] dat_r;
  logic                 ack;
  logic                 stall;

  modport master (
    output addr, dat_w, sel, cti, cyc, stb, we,
    input  dat_r, ack, stall
  );

  modport slave (
    input  addr, dat_w, sel, cti, cyc, stb, we,
    output dat_r, ack, stall
  );

endinterface

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for wb_arb2.
// WB_ARB_RR_EN selects round-robin; otherwise m1 has fixed priority over m0.
module wb_arb_pick (
  input  logic req0_i,
  input  logic req1_i,
`ifdef WB_ARB_RR_EN
  input  logic last_i,
`endif
  output logic valid_o,
  output logic pick_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
`ifdef WB_ARB_RR_EN
    // On a tie the master not granted last time wins.
    if (req0_i && req1_i) begin
      pick_o = ~last_i;
    end else begin
      pick_o = req1_i;
    end
`else
    pick_o = req1_i;
`endif
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone pipelined arbiter with outstanding-access tracking.
// Define WB_ARB_RR_EN for round-robin arbitration (default: fixed priority, m1 over m0).
module wb_arb2
  import wb_pkg::*;
#(
  parameter int unsigned OUTSTANDING_W = 2
) (
  input logic       clk_i,
  input logic       rst_ni,
  wb_arb2_if.slave  m0,
  wb_arb2_if.slave  m1,
  wb_arb2_if.master s
);

  arb_state_e               state_q, state_d;
  logic [OUTSTANDING_W-1:0] cnt_q, cnt_d;
  logic                     full, cnt_nz;
  logic                     pick_valid, pick;
  logic                     accept, ack_fwd;

  assign full    = (cnt_q == {OUTSTANDING_W{1'b1}});
  assign cnt_nz  = (cnt_q != '0);
  assign accept  = s.stb & ~s.stall;
  assign ack_fwd = s.ack & cnt_nz & (state_q != StIdle);

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

`ifdef WB_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else if (state_q == StIdle && pick_valid) begin
      last_q <= pick;
    end
  end
`endif

  wb_arb_pick u_pick (
    .req0_i  (m0.cyc),
    .req1_i  (m1.cyc),
`ifdef WB_ARB_RR_EN
    .last_i  (last_q),
`endif
    .valid_o (pick_valid),
    .pick_o  (pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pick_valid) state_d = pick ? StOwn1 : StOwn0;
      StOwn0: if (!m0.cyc) state_d = StIdle;
      StOwn1: if (!m1.cyc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Dropping ownership aborts whatever is in flight; late acks then see a zero count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StIdle && state_d == StIdle) begin
      cnt_d = '0;
    end else if (accept && !ack_fwd) begin
      cnt_d = cnt_q + OUTSTANDING_W'(1);
    end else if (!accept && ack_fwd) begin
      cnt_d = cnt_q - OUTSTANDING_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = '0;
    s.dat_w  = '0;
    s.sel    = '0;
    s.cti    = '0;
    m0.stall = 1'b1;
    m0.ack   = 1'b0;
    m1.stall = 1'b1;
    m1.ack   = 1'b0;
    unique case (state_q)
      StOwn0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb & ~full;
        s.we     = m0.we;
        s.addr   = m0.addr;
        s.dat_w  = m0.dat_w;
        s.sel    = m0.sel;
        s.cti    = m0.cti;
        m0.stall = s.stall | full;
        m0.ack   = s.ack & cnt_nz;
      end
      StOwn1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb & ~full;
        s.we     = m1.we;
        s.addr   = m1.addr;
        s.dat_w  = m1.dat_w;
        s.sel    = m1.sel;
        s.cti    = m1.cti;
        m1.stall = s.stall | full;
        m1.ack   = s.ack & cnt_nz;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed scenarios plus random traffic, all cycles
// compared against a transaction-level reference model of the arbiter.
module tb_wb_arb2;
  import wb_pkg::*;

  localparam int OW     = 2;
  localparam int MaxOut = (1 << OW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_arb2_if m0_if ();
  wb_arb2_if m1_if ();
  wb_arb2_if s_if ();

  wb_arb2 #(
    .OUTSTANDING_W (OW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the slave (0 none, 1 m0, 2 m1) and accesses in flight.
  int own_m  = 0;
  int outst  = 0;
`ifdef WB_ARB_RR_EN
  int last_m = 0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_m(input int m, input bit cyc, input bit stb, input logic [31:0] addr);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.addr = addr;
      m0_if.we = 1'($urandom); m0_if.sel = 4'($urandom); m0_if.dat_w = $urandom;
      m0_if.cti = ($urandom % 2 == 0) ? WB_CTI_CLASSIC : WB_CTI_INCR;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.addr = addr;
      m1_if.we = 1'($urandom); m1_if.sel = 4'($urandom); m1_if.dat_w = $urandom;
      m1_if.cti = ($urandom % 2 == 0) ? WB_CTI_END : WB_CTI_INCR;
    end
  endtask

  task automatic slave_resp(input bit ack, input bit stall, input logic [31:0] dat);
    s_if.ack = ack; s_if.stall = stall; s_if.dat_r = dat;
  endtask

  task automatic model_reset();
    own_m = 0;
    outst = 0;
`ifdef WB_ARB_RR_EN
    last_m = 0;
`endif
  endtask

  // Compare every DUT output for the current cycle, then advance the model one edge.
  task automatic model_cycle();
    logic [73:0] mreq, exp_req, obs_req;
    bit full, exp_stb, exp_stall, exp_ack, acc;
    int win;
    full = (outst == MaxOut);
    if (own_m == 1) mreq = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.cti,
                            m0_if.addr, m0_if.dat_w};
    else if (own_m == 2) mreq = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.cti,
                                 m1_if.addr, m1_if.dat_w};
    else mreq = '0;
    exp_stb   = (own_m != 0) && mreq[72] && !full;
    exp_req   = mreq;
    exp_req[72] = exp_stb;
    exp_stall = s_if.stall || full;
    exp_ack   = s_if.ack && (outst > 0);
    obs_req = {s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.cti, s_if.addr, s_if.dat_w};
    chk("s_req", obs_req, exp_req);
    chk("m0_stall_ack", {m0_if.stall, m0_if.ack}, (own_m == 1) ? {exp_stall, exp_ack} : 2'b10);
    chk("m1_stall_ack", {m1_if.stall, m1_if.ack}, (own_m == 2) ? {exp_stall, exp_ack} : 2'b10);
    chk("m_data", {m0_if.dat_r, m1_if.dat_r}, {s_if.dat_r, s_if.dat_r});
    if (!rst_n) return;
    acc = exp_stb && !s_if.stall;
    if (own_m == 0) begin
      if (m0_if.cyc || m1_if.cyc) begin
`ifdef WB_ARB_RR_EN
        win = (m0_if.cyc && m1_if.cyc) ? ((last_m == 1) ? 0 : 1) : (m1_if.cyc ? 1 : 0);
        last_m = win;
`else
        win = m1_if.cyc ? 1 : 0;
`endif
        own_m = win + 1;
      end
    end else if (!mreq[73]) begin
      own_m = 0;
      outst = 0;
    end else begin
      outst = outst + (acc ? 1 : 0) - (exp_ack ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  int n_acc;
  int who;
  int exp_who;
  bit got;

  initial begin
    drive_m(0, 0, 0, 32'h0);
    drive_m(1, 0, 0, 32'h0);
    slave_resp(0, 0, 32'h0);
    model_reset();
    #2;
    chk("rst_stalls", {m0_if.stall, m1_if.stall}, 2'b11);
    chk("rst_cyc_stb_ack", {s_if.cyc, s_if.stb, m0_if.ack, m1_if.ack}, 4'b0000);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read from m0.
    drive_m(0, 1, 1, 32'h100);
    tick();
    chk("rd_addr", {s_if.stb, s_if.addr}, {1'b1, 32'h100});
    tick();
    drive_m(0, 1, 0, 32'h100);
    slave_resp(1, 0, 32'hDEADBEEF);
    #1;
    chk("rd_ack", {m0_if.ack, m1_if.ack, m0_if.dat_r}, {1'b1, 1'b0, 32'hDEADBEEF});
    tick();
    slave_resp(0, 0, 32'h0);
    drive_m(0, 0, 0, 32'h0);
    tick();

    // Simultaneous requests: m1 first, m0 waits for handover.
    drive_m(0, 1, 1, 32'h200);
    drive_m(1, 1, 1, 32'h300);
    tick();
    chk("both_grant_m1", {m1_if.stall, m0_if.stall, s_if.addr}, {1'b0, 1'b1, 32'h300});
    tick();
    drive_m(1, 1, 0, 32'h300);
    slave_resp(1, 0, $urandom);
    tick();
    slave_resp(0, 0, 32'h0);
    drive_m(1, 0, 0, 32'h0);
    #1;
    chk("hand_k_m0_stall", m0_if.stall, 1'b1);
    tick();
    chk("hand_k1_idle", {s_if.stb, m0_if.stall}, 2'b01);
    tick();
    chk("hand_k2_m0", {s_if.stb, s_if.addr, m0_if.stall}, {1'b1, 32'h200, 1'b0});
    tick();
    drive_m(0, 1, 0, 32'h200);
    slave_resp(1, 0, $urandom);
    tick();
    slave_resp(0, 0, 32'h0);
    drive_m(0, 0, 0, 32'h0);
    tick();

    // Outstanding limit with acks withheld, then one ack frees one slot.
    drive_m(0, 1, 1, 32'h400);
    tick();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_if.stb && !s_if.stall) n_acc++;
      tick();
    end
    chk("limit_accepts", n_acc, 3);
    chk("limit_stall", {m0_if.stall, s_if.stb}, 2'b10);
    slave_resp(1, 0, 32'h0);
    n_acc = 0;
    if (s_if.stb && !s_if.stall) n_acc++;
    tick();
    slave_resp(0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (s_if.stb && !s_if.stall) n_acc++;
      tick();
    end
    chk("limit_after_ack", n_acc, 1);
    drive_m(0, 0, 0, 32'h0);
    tick();

    // Abort with one access in flight; the late ack must be discarded.
    drive_m(0, 1, 1, 32'h500);
    tick();
    tick();
    drive_m(0, 0, 0, 32'h0);
    tick();
    slave_resp(1, 0, 32'h12345678);
    #1;
    chk("abort_late_ack", {m0_if.ack, m1_if.ack}, 2'b00);
    tick();
    slave_resp(0, 0, 32'h0);
    drive_m(1, 1, 0, 32'h600);
    tick();
    slave_resp(1, 0, 32'h0);
    #1;
    chk("spurious_ack", {m0_if.ack, m1_if.ack}, 2'b00);
    tick();
    slave_resp(0, 0, 32'h0);

    // Reset mid-burst with m1 holding two outstanding accesses.
    drive_m(1, 1, 1, 32'h700);
    tick();
    tick();
    slave_resp(1, 0, 32'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_cyc", {s_if.cyc, s_if.stb, m1_if.ack}, 3'b000);
    chk("rst_mid_stalls", {m0_if.stall, m1_if.stall}, 2'b11);
    drive_m(1, 0, 0, 32'h0);
    slave_resp(0, 0, 32'h0);
    tick();
    rst_n = 1'b1;
    drive_m(0, 1, 1, 32'h800);
    tick();
    chk("post_rst_req", {s_if.stb, s_if.addr}, {1'b1, 32'h800});
    tick();
    drive_m(0, 1, 0, 32'h800);
    slave_resp(1, 0, 32'hCAFEF00D);
    #1;
    chk("post_rst_ack", {m0_if.ack, m0_if.dat_r}, {1'b1, 32'hCAFEF00D});
    tick();
    slave_resp(0, 0, 32'h0);
    drive_m(0, 0, 0, 32'h0);
    tick();

    // Continuous single-beat cycles from both masters: grant order.
    for (int g = 0; g < 4; g++) begin
      drive_m(0, 1, 1, 32'hA0);
      drive_m(1, 1, 1, 32'hB0);
      got = 0;
      for (int w = 0; w < 6 && !got; w++) begin
        tick();
        got = s_if.stb;
      end
      if (!got) begin
        chk("rr_grant_timeout", 1'b0, 1'b1);
      end else begin
        who = (s_if.addr == 32'hB0) ? 1 : 0;
`ifdef WB_ARB_RR_EN
        exp_who = (g % 2 == 0) ? 1 : 0;
`else
        exp_who = 1;
`endif
        chk("grant_order", who, exp_who);
        tick();
        drive_m(who, 1, 0, (who == 1) ? 32'hB0 : 32'hA0);
        slave_resp(1, 0, $urandom);
        tick();
        slave_resp(0, 0, 32'h0);
        drive_m(who, 0, 0, 32'h0);
        tick();
      end
    end
    drive_m(0, 0, 0, 32'h0);
    drive_m(1, 0, 0, 32'h0);
    tick();
    tick();

    // Random traffic, including stalls and spurious acks.
    for (int i = 0; i < 400; i++) begin
      drive_m(0, ($urandom % 8 == 0) ? !m0_if.cyc : m0_if.cyc, 1'($urandom), $urandom);
      drive_m(1, ($urandom % 8 == 0) ? !m1_if.cyc : m1_if.cyc, 1'($urandom), $urandom);
      slave_resp($urandom % 3 == 0, $urandom % 4 == 0, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master to one-slave Wishbone pipelined arbiter that sits directly upstream of the on-chip RAM slave. It merges the CPU instruction-fetch port (m0) and data port (m1) onto a single slave bus. It holds the grant for a whole `cyc` and tracks outstanding accesses so that each ack is returned to the correct master. The slave is assumed to be pipelined: acks arrive in order, and `stall` may be asserted.

## Interface
- `OUTSTANDING_W`, default 2: width of the outstanding-access counter. Maximum in flight is 2^W−1.
- `clk_i` input 1: clock; all state changes on its rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `m0_addr_i` / `m1_addr_i` input 32: master byte address.
- `m0_data_i` / `m1_data_i` input 32: master write data.
- `m0_sel_i` / `m1_sel_i` input 4: byte selects.
- `m0_cyc_i` / `m1_cyc_i` input 1: bus cycle request; held for the duration of the ownership.
- `m0_stb_i` / `m1_stb_i` input 1: access strobe.
- `m0_cti_i` / `m1_cti_i` input 3: cycle type, passed through unchanged.
- `m0_we_i` / `m1_we_i` input 1: write enable.
- `m_data_o` output 32: read data, broadcast to both masters and qualified by `mN_ack_o`.
- `m0_ack_o` / `m1_ack_o` output 1: access complete.
- `m0_stall_o` / `m1_stall_o` output 1: access not accepted this cycle.
- `s_addr_o`, `s_data_o`, `s_sel_o`, `s_cti_o`, `s_we_o` output 32/32/4/3/1: muxed request to the slave.
- `s_cyc_o`, `s_stb_o` output 1: slave cycle and strobe.
- `s_data_i` input 32, `s_ack_i` input 1, `s_stall_i` input 1: slave response.

## Operation
- **State machine:**
  - IDLE → OWN0 or OWN1 when the corresponding `mN_cyc_i` is high. If both are high, the configured priority (see Configuration) decides.
  - OWNn → IDLE when `mN_cyc_i` is low.
- **Registered grant.** Winner selection in IDLE takes effect on the next edge.
- **Muxing.** In OWNn, all `s_*` request signals equal master n's inputs. In IDLE, `s_cyc_o`, `s_stb_o` and `s_we_o` are 0, and address, data, sel and cti are 0.
- **Owner stall.** `mN_stall_o = s_stall_i | full` for the owner.
- **Non-owner.** `stall_o` is 1 and `ack_o` is 0.
- **Slave strobe.** `s_stb_o = owner_stb & ~full`.
- **Outstanding counter:**
  - +1 on an accepted access (`s_stb_o & ~s_stall_i`).
  - −1 on `s_ack_i`.
  - Accept and ack in the same cycle leaves it unchanged.
  - `full` = counter at 2^W−1. Ack-in and stall are evaluated with the current count.
- **Ack routing.** `s_ack_i` is forwarded as owner `ack_o` only while counter ≠ 0. `m_data_o = s_data_i`.
- **Early cyc drop.** If the owner drops `cyc` with accesses outstanding, the transaction is aborted: the counter clears on the transition to IDLE, and late `s_ack_i` is discarded.
- **Spurious ack.** `s_ack_i` with counter 0 is dropped and never forwarded.
- **Reset values:**
  - State IDLE, counter 0, last-grant = m0.
  - `m0_stall_o` = `m1_stall_o` = 1.
  - All acks, `s_cyc_o` and `s_stb_o` are 0.

## Timing
- **Arbitration latency:** a request (`cyc` & `stb`) at edge N in IDLE is presented on `s_stb_o` during cycle N+1. The master holds `stb` because it saw stall.
- **Zero-wait slave:** the first `mN_ack_o` arrives at N+2. Back-to-back strobes then proceed at one per cycle.
- **Handover:** owner `cyc` low in cycle K → IDLE at K+1 → new owner drives the slave at K+2. There is one dead cycle minimum.
- **Combinational paths:** ack, stall and data are combinational from the slave to the owner, with zero added latency.
- **Reset:** assertion mid-transfer forces all reset values immediately, independent of the clock.

## Configuration
- **`WB_ARB_RR_EN` defined:** round-robin. On a tie, the master not granted last wins. last-grant updates on every IDLE→OWN transition.
- **`WB_ARB_RR_EN` undefined:** fixed priority, m1 (data) over m0. The last-grant register is not implemented.

## Structure
- **Package `wb_pkg`:**
  - Arbiter state enum (IDLE/OWN0/OWN1).
  - `WB_CTI_CLASSIC` = 3'b000, `WB_CTI_INCR` = 3'b010, `WB_CTI_END` = 3'b111.
  - Address and data width constants.
- **Sub-module `wb_arb_pick`:** combinational winner selection from the two requests and last-grant. This is where the `WB_ARB_RR_EN` variants live.

## Test plan
- **Single read:** m0 `cyc`/`stb` addr 0x100 at cycle 0; slave acks at cycle 2 with 0xDEADBEEF → `s_addr_o` = 0x100 in cycle 1, `m0_ack_o` in cycle 2, `m_data_o` = 0xDEADBEEF. `m1_ack_o` stays 0 throughout.
- **Simultaneous requests, fixed priority:** m1 granted first. m0 stall stays 1 until m1 drops `cyc` at K. m0 strobe reaches the slave at K+2.
- **Round-robin (`WB_ARB_RR_EN`):** both masters issue continuous single-beat cycles → grant order m1, m0, m1, m0.
- **Outstanding limit:** W=2, `s_stall_i` = 0, acks withheld → exactly 3 accesses accepted, then owner stall = 1 and `s_stb_o` = 0. One ack → one further access accepted.
- **Abort:** owner drops `cyc` with 1 outstanding → the late `s_ack_i` reaches neither `m0_ack_o` nor `m1_ack_o`. The counter is 0 in IDLE.
- **Reset mid-burst:** `rst_ni` low during OWN1 with 2 outstanding → state IDLE and `s_cyc_o` = 0 immediately, both stalls = 1. After release, a fresh m0 request succeeds.
